rdwr_fifo_sync: RTL and testbench

//   Single-clock FIFO that sits on the consumer side of a read/write port pair.
//   A writer pushes words and a reader pops them; full, empty and count flags

---
 rtl/rdwr_fifo_sync.sv | 109 ++++++++++
 tb/tb_rdwr_fifo_sync.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rdwr_fifo_sync.sv
// Single-clock FIFO with registered read data, registered full/empty flags
// and one-cycle overflow/underflow pulses for refused requests.
module rdwr_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_acc, wr_acc;

  always_comb begin
    // A write into a full FIFO is only possible because a pop frees the slot.
    rd_acc      = rd_en & ~empty_q;
    wr_acc      = wr_en & (~full_q | rd_acc);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      rd_data_d  = mem[rd_ptr_q];
      rd_valid_d = 1'b1;
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CNT_ONE;
    end

    full_d      = (count_d == CNT_FULL);
    empty_d     = (count_d == '0);
    overflow_d  = wr_en & ~wr_acc;
    underflow_d = rd_en & empty_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_rdwr_fifo_sync.sv
// Directed bench for rdwr_fifo_sync with hand-computed expectations.
module tb_rdwr_fifo_sync;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int vec_cnt  = 0;
  int miscomp  = 0;

  rdwr_fifo_sync #(.WIDTH(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscomp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    #12 rst = 1'b0;
    step();

    // 1: reset state
    chk("rst_empty",    32'(empty), 32'd1);
    chk("rst_full",     32'(full), 32'd0);
    chk("rst_count",    32'(count), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data",  32'(rd_data), 32'h00);

    // 2: three writes then three reads
    wr_en = 1'b1; wr_data = 8'h11; step();
    chk("t2_count1", 32'(count), 32'd1);
    chk("t2_empty1", 32'(empty), 32'd0);
    wr_data = 8'h22; step();
    wr_data = 8'h33; step();
    chk("t2_count3", 32'(count), 32'd3);
    wr_en = 1'b0; rd_en = 1'b1; step();
    chk("t2_rv0", 32'(rd_valid), 32'd1);
    chk("t2_rd0", 32'(rd_data), 32'h11);
    step();
    chk("t2_rd1", 32'(rd_data), 32'h22);
    step();
    chk("t2_rd2", 32'(rd_data), 32'h33);
    chk("t2_rv2", 32'(rd_valid), 32'd1);
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_count0", 32'(count), 32'd0);
    rd_en = 1'b0; step();
    chk("t2_rv_idle", 32'(rd_valid), 32'd0);
    chk("t2_rd_hold", 32'(rd_data), 32'h33);
    chk("t2_no_uflow", 32'(underflow), 32'd0);

    // 3: fill to DEPTH, then one refused write
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'h80 + 8'(i);
      step();
    end
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_no_oflow", 32'(overflow), 32'd0);
    wr_data = 8'hEE; step();
    chk("t3_oflow", 32'(overflow), 32'd1);
    chk("t3_count_hold", 32'(count), 32'd16);
    wr_en = 1'b0; step();
    chk("t3_oflow_clr", 32'(overflow), 32'd0);

    // 4: simultaneous read/write while full, then drain across the wrap
    rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'hAA; step();
    chk("t4_rd_first", 32'(rd_data), 32'h80);
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_no_oflow", 32'(overflow), 32'd0);
    wr_en = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("t4_drain", 32'(rd_data), 32'h80 + 32'(i));
    end
    step();
    chk("t4_last_aa", 32'(rd_data), 32'hAA);
    chk("t4_rv_last", 32'(rd_valid), 32'd1);
    chk("t4_empty", 32'(empty), 32'd1);
    rd_en = 1'b0; step();

    // 5: simultaneous read/write while empty
    rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'h55; step();
    chk("t5_uflow", 32'(underflow), 32'd1);
    chk("t5_count", 32'(count), 32'd1);
    chk("t5_rv", 32'(rd_valid), 32'd0);
    chk("t5_empty", 32'(empty), 32'd0);
    wr_en = 1'b0; step();
    chk("t5_rd", 32'(rd_data), 32'h55);
    chk("t5_rv2", 32'(rd_valid), 32'd1);
    chk("t5_uflow_clr", 32'(underflow), 32'd0);
    rd_en = 1'b0; step();

    // 6: async reset between edges with count = 5 and rd_valid high
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'hC0 + 8'(i);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b1; step();
    rd_en = 1'b0;
    chk("t6_pre_count", 32'(count), 32'd5);
    chk("t6_pre_rv", 32'(rd_valid), 32'd1);
    chk("t6_pre_rd", 32'(rd_data), 32'hC0);
    #2 rst = 1'b1;
    #1;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_full", 32'(full), 32'd0);
    chk("t6_rv", 32'(rd_valid), 32'd0);
    chk("t6_rd", 32'(rd_data), 32'h00);
    #2 rst = 1'b0;
    step();
    wr_en = 1'b1; wr_data = 8'h77; step();
    wr_en = 1'b0; rd_en = 1'b1; step();
    chk("t6_post_rd", 32'(rd_data), 32'h77);
    chk("t6_post_empty", 32'(empty), 32'd1);
    rd_en = 1'b0; step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscomp);
    $finish;
  end

endmodule
